// File: rtl/dmem_pkg.sv
// Shared types for the data-memory stage: load/store width encoding,
// MMIO register offsets and TX_STATUS bit positions.
package dmem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_e;

    localparam logic [5:0] MMIO_LED     = 6'h00;
    localparam logic [5:0] MMIO_CYC_LO  = 6'h04;
    localparam logic [5:0] MMIO_CYC_HI  = 6'h08;
    localparam logic [5:0] MMIO_TX_DATA = 6'h0C;
    localparam logic [5:0] MMIO_TX_STAT = 6'h10;

    localparam int TXS_FULL    = 0;
    localparam int TXS_EMPTY   = 1;
    localparam int TXS_OVF     = 2;
    localparam int TXS_CNT_LSB = 4;

endpackage

// File: rtl/dmem_if.sv
// Core-side data bus plus the TX byte stream of the memory stage.
// master: core / consumer side; slave: dmem_unit.
interface dmem_if;
    import dmem_pkg::*;

    logic [31:0] data_addr;
    logic [31:0] data_write;
    logic        data_we;
    logic [2:0]  MemOp;
    logic [31:0] data_read;
    logic        misalign;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output data_addr, data_write, data_we, MemOp, tx_ready,
        input  data_read, misalign, tx_data, tx_valid
    );

    modport slave (
        input  data_addr, data_write, data_we, MemOp, tx_ready,
        output data_read, misalign, tx_data, tx_valid
    );

endinterface

// File: rtl/tx_fifo.sv
// Circular byte FIFO feeding the TX stream; sticky overflow when a push
// hits a full queue with no simultaneous pop.
// Ports: clk, rst (async, high), push/din, pop_req, clr_ovf,
//        dout (head, 0 when empty), valid, full, empty, count, overflow.
module tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop_req,
    input  logic                     clr_ovf,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      cnt;
    logic             ovf;
    logic             pop;
    logic             wr;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (PW+1)'(DEPTH));
    assign pop      = pop_req && !empty;
    // A full queue still accepts a byte when the head leaves on the same edge.
    assign wr       = push && (!full || pop);
    assign valid    = !empty;
    assign dout     = empty ? '0 : buf_q[rd_ptr];
    assign count    = cnt;
    assign overflow = ovf;

    always_ff @(posedge clk) begin
        if (wr) begin
            buf_q[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // Dropping a byte outranks a same-edge clear request.
            if (push && !wr) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_unit.sv
// Data-memory stage of the single-cycle RV32I core: byte-lane word RAM,
// LED register, 64-bit cycle counter and TX FIFO in a 64 B MMIO window.
// Ports: clk, rst (async, high), bus (dmem_if.slave: address, store data,
//        MemOp, load result, misalign, TX stream), led[15:0].
// Option: DMEM_MISALIGN_TRAP_EN flags misaligned H/W accesses and blocks
//        them; without it such accesses are forced to natural alignment.
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int unsigned TXQ_DEPTH   = 8,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    dmem_if.slave       bus,
    output logic [15:0] led
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam int          CW        = $clog2(TXQ_DEPTH) + 1;
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    logic [31:0]   mem [DEPTH_WORDS];

    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          ram_hit;
    logic          mmio_hit;
    logic          is_b;
    logic          is_h;
    logic          is_w;
    logic          mis;
    logic          acc_ok;
    logic [AW-1:0] widx;
    logic [5:0]    moff;
    logic [31:0]   mmio_rd;
    logic [31:0]   word_rd;
    logic [7:0]    byte_rd;
    logic [15:0]   half_rd;
    logic [31:0]   wrep;
    logic [3:0]    be;
    logic          st_ok;
    logic          ram_we;
    logic          mmio_we;
    logic          led_we;
    logic          tx_push;
    logic          ovf_clr;
    logic [63:0]   cycle;
    logic [31:0]   stat;
    logic          tx_full;
    logic          tx_empty;
    logic [CW-1:0] tx_count;
    logic          tx_ovf;

    assign addr     = bus.data_addr;
    assign wdata    = bus.data_write;
    assign ram_hit  = ({1'b0, addr} < RAM_BYTES);
    assign mmio_hit = (addr[31:6] == MMIO_BASE[31:6]);
    assign widx     = addr[AW+1:2];
    assign moff     = {addr[5:2], 2'b00};

    always_comb begin
        is_b = 1'b0;
        is_h = 1'b0;
        is_w = 1'b0;
        case (bus.MemOp)
            MEM_B, MEM_BU: is_b = 1'b1;
            MEM_H, MEM_HU: is_h = 1'b1;
            MEM_W:         is_w = 1'b1;
            default:       ;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign bus.misalign = mis;
    assign acc_ok       = (is_b || is_h || is_w) && !mis;

    always_comb begin
        stat                        = '0;
        stat[TXS_FULL]              = tx_full;
        stat[TXS_EMPTY]             = tx_empty;
        stat[TXS_OVF]               = tx_ovf;
        stat[TXS_CNT_LSB +: 4]      = 4'(tx_count);
    end

    always_comb begin
        mmio_rd = '0;
        case (moff)
            MMIO_LED:     mmio_rd = {16'h0000, led};
            MMIO_CYC_LO:  mmio_rd = cycle[31:0];
            MMIO_CYC_HI:  mmio_rd = cycle[63:32];
            MMIO_TX_STAT: mmio_rd = stat;
            default:      mmio_rd = '0;
        endcase
    end

    always_comb begin
        word_rd = '0;
        if (acc_ok && ram_hit) begin
            word_rd = mem[widx];
        end else if (acc_ok && mmio_hit && is_w) begin
            word_rd = mmio_rd;
        end
    end

    assign byte_rd = word_rd[{addr[1:0], 3'b000} +: 8];
    assign half_rd = addr[1] ? word_rd[31:16] : word_rd[15:0];

    always_comb begin
        bus.data_read = '0;
        case (bus.MemOp)
            MEM_B:   bus.data_read = {{24{byte_rd[7]}}, byte_rd};
            MEM_BU:  bus.data_read = {24'h0, byte_rd};
            MEM_H:   bus.data_read = {{16{half_rd[15]}}, half_rd};
            MEM_HU:  bus.data_read = {16'h0, half_rd};
            MEM_W:   bus.data_read = word_rd;
            default: bus.data_read = '0;
        endcase
    end

    // Store data is replicated so every enabled lane sees the right byte.
    always_comb begin
        wrep = wdata;
        be   = 4'h0;
        if (is_b) begin
            wrep = {4{wdata[7:0]}};
            be   = 4'b0001 << addr[1:0];
        end else if (is_h) begin
            wrep = {2{wdata[15:0]}};
            be   = addr[1] ? 4'b1100 : 4'b0011;
        end else if (is_w) begin
            be   = 4'hF;
        end
    end

    assign st_ok   = bus.data_we && acc_ok;
    assign ram_we  = st_ok && ram_hit;
    assign mmio_we = st_ok && mmio_hit && is_w;
    assign led_we  = mmio_we && (moff == MMIO_LED);
    assign tx_push = mmio_we && (moff == MMIO_TX_DATA);
    assign ovf_clr = mmio_we && (moff == MMIO_TX_STAT);

    // RAM is not reset, but a store landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wrep[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led   <= '0;
            cycle <= '0;
        end else begin
            cycle <= cycle + 64'd1;
            if (led_we) begin
                led <= wdata[15:0];
            end
        end
    end

    tx_fifo #(
        .WIDTH (8),
        .DEPTH (TXQ_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push),
        .din      (wdata[7:0]),
        .pop_req  (bus.tx_ready),
        .clr_ovf  (ovf_clr),
        .dout     (bus.tx_data),
        .valid    (bus.tx_valid),
        .full     (tx_full),
        .empty    (tx_empty),
        .count    (tx_count),
        .overflow (tx_ovf)
    );

endmodule

// File: tb/tb_dmem_unit.sv
// Scoreboard bench for dmem_unit: directed scenarios then random traffic
// against a byte-addressed reference model of RAM, MMIO and the TX queue.
module tb_dmem_unit;
    import dmem_pkg::*;

    localparam int          DEPTH = 8;
    localparam logic [31:0] MB    = 32'h8000_0000;
    localparam logic [31:0] RAMB  = 32'h0001_0000;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] led;

    dmem_if bus();

    dmem_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .led (led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        txv;
        logic [15:0] led;
        string       name;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          pops   = 0;
    exp_t        expq[$];
    logic [7:0]  sbq[$];
    logic        req_v  = 1'b0;

    logic [7:0]  mb [int unsigned];
    logic [15:0] led_m  = '0;
    logic [63:0] cyc_m;
    logic [7:0]  mq[$];
    logic        ovf_m  = 1'b0;

    logic [31:0] c_addr = '0;
    logic [31:0] c_wd   = '0;
    logic        c_we   = 1'b0;
    logic [2:0]  c_op   = 3'b010;
    logic        c_rdy  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc_m <= '0;
        else     cyc_m <= cyc_m + 64'd1;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic int osize(input logic [2:0] op);
        case (op)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit is_mis(input logic [31:0] a, input logic [2:0] op);
        int sz = osize(op);
        return TRAP && sz > 1 && (a % sz) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a,
                                               input logic [2:0] op);
        int          sz = osize(op);
        logic [31:0] base;
        logic [31:0] v = '0;
        if (sz == 0 || is_mis(a, op)) return '0;
        base = a - (a % sz);
        if (a < RAMB) begin
            for (int i = 0; i < sz; i++)
                v = v | (32'(mb[base + i]) << (8 * i));
            if (op == 3'b000 && v >= 128)   v = v + 32'hFFFF_FF00;
            if (op == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
            return v;
        end
        if (a[31:6] == MB[31:6]) begin
            if (sz != 4) return '0;
            case (a[5:0] - a[5:0] % 4)
                6'h00: return 32'(led_m);
                6'h04: return cyc_m[31:0];
                6'h08: return cyc_m[63:32];
                6'h10: return (mq.size() == DEPTH ? 1 : 0)
                            + (mq.size() == 0 ? 2 : 0)
                            + (ovf_m ? 4 : 0) + mq.size() * 16;
                default: return '0;
            endcase
        end
        return '0;
    endfunction

    // Applies the effect of the cycle that just ended at a rising edge.
    task automatic model_commit();
        bit          pop = (mq.size() != 0) && c_rdy;
        bit          setv = 0;
        bit          clr = 0;
        int          sz = osize(c_op);
        logic [31:0] base;
        if (c_we && sz != 0 && !is_mis(c_addr, c_op)) begin
            base = c_addr - (c_addr % sz);
            if (c_addr < RAMB) begin
                for (int i = 0; i < sz; i++)
                    mb[base + i] = c_wd[8*i +: 8];
            end else if (c_addr[31:6] == MB[31:6] && sz == 4) begin
                case (base[5:0])
                    6'h00: led_m = c_wd[15:0];
                    6'h0C: begin
                        if (mq.size() < DEPTH || pop) begin
                            mq.push_back(c_wd[7:0]);
                            sbq.push_back(c_wd[7:0]);
                        end else begin
                            setv = 1;
                        end
                    end
                    6'h10: clr = 1;
                    default: ;
                endcase
            end
        end
        if (pop) void'(mq.pop_front());
        if (setv)     ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic [2:0] op,
                        input logic rdy, input string nm,
                        input bit kon, input logic [31:0] kv);
        exp_t e;
        @(posedge clk);
        model_commit();
        #1;
        bus.data_addr  = a;
        bus.data_write = d;
        bus.data_we    = we;
        bus.MemOp      = op;
        bus.tx_ready   = rdy;
        c_addr = a; c_wd = d; c_we = we; c_op = op; c_rdy = rdy;
        e.rd   = kon ? kv : model_load(a, op);
        e.mis  = is_mis(a, op);
        e.txv  = (mq.size() != 0);
        e.led  = led_m;
        e.name = nm;
        expq.push_back(e);
        req_v = 1'b1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] op, input logic rdy);
        step(a, d, 1'b1, op, rdy, "store", 0, '0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] op,
                      input logic rdy);
        step(a, $urandom, 1'b0, op, rdy, "load", 0, '0);
    endtask

    task automatic ldk(input logic [31:0] a, input logic [2:0] op,
                       input logic [31:0] kv, input string nm);
        step(a, '0, 1'b0, op, 1'b0, nm, 1, kv);
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (req_v) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got output, want queued item");
            end else begin
                me = expq.pop_front();
                check({me.name, " data_read"}, bus.data_read, me.rd);
                check({me.name, " misalign"}, 32'(bus.misalign), 32'(me.mis));
                check({me.name, " tx_valid"}, 32'(bus.tx_valid), 32'(me.txv));
                check({me.name, " led"}, 32'(led), 32'(me.led));
            end
        end
        if (bus.tx_valid && bus.tx_ready) begin
            pops++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_data: got %h, want no byte", bus.tx_data);
            end else begin
                check("tx_data", 32'(bus.tx_data), 32'(sbq.pop_front()));
            end
        end
    end

    logic [31:0] v1;
    logic [31:0] v2;
    int          p0;
    logic [31:0] ra;
    logic [2:0]  rop;
    int          cls;

    initial begin
        bus.data_addr  = MB + 32'h4;
        bus.data_write = '0;
        bus.data_we    = 1'b0;
        bus.MemOp      = MEM_W;
        bus.tx_ready   = 1'b0;
        c_addr = MB + 32'h4;
        repeat (2) @(posedge clk);
        #1;
        check("rst led", 32'(led), 32'h0);
        check("rst tx_valid", 32'(bus.tx_valid), 32'h0);
        check("rst tx_data", 32'(bus.tx_data), 32'h0);
        check("rst cycle", bus.data_read, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 64; i++) st(i * 4, $urandom, MEM_W, 1'b0);
        for (int i = 0; i < 4; i++) st(32'hFFF0 + i * 4, $urandom, MEM_W, 1'b0);

        st(32'h0, 32'h1122_3344, MEM_W, 1'b0);
        st(32'h3, 32'h0000_0080, MEM_B, 1'b0);
        ldk(32'h3, MEM_B,  32'hFFFF_FF80, "lb_sign");
        ldk(32'h3, MEM_BU, 32'h0000_0080, "lbu_zero");
        ldk(32'h0, MEM_W,  32'h8022_3344, "lw_after_sb");

        st(32'h10, 32'h1234_5678, MEM_W, 1'b0);
        st(32'h12, 32'h0000_BEEF, MEM_H, 1'b0);
        ldk(32'h12, MEM_HU, 32'h0000_BEEF, "lhu");
        ldk(32'h12, MEM_H,  32'hFFFF_BEEF, "lh");
        ldk(32'h10, MEM_W,  32'hBEEF_5678, "lw_after_sh");

        for (int i = 0; i < 9; i++) st(MB + 32'hC, 32'hA0 + i, MEM_W, 1'b0);
        ldk(MB + 32'h10, MEM_W, 32'h85, "status_full_ovf");

        p0 = pops;
        repeat (8) ld(32'h4000_0000, MEM_W, 1'b1);
        st(MB + 32'h10, 32'h0, MEM_W, 1'b0);
        check("pops_per_cycle", 32'(pops - p0), 32'd8);
        ldk(MB + 32'h10, MEM_W, 32'h02, "status_empty");

        for (int i = 0; i < 8; i++) st(MB + 32'hC, 32'h30 + i, MEM_W, 1'b0);
        st(MB + 32'hC, 32'h5A, MEM_W, 1'b1);
        ldk(MB + 32'h10, MEM_W, 32'h81, "status_push_pop_full");
        repeat (9) ld(32'h4000_0000, MEM_W, 1'b1);
        ld(32'h4000_0000, MEM_W, 1'b0);
        check("drain_push_pop", 32'(sbq.size()), 32'd0);

        st(32'h2, 32'hDEAD_BEEF, MEM_W, 1'b0);
        ld(32'h0, MEM_W, 1'b0);
        ld(32'h0, MEM_H, 1'b0);

        ld(MB + 32'h4, MEM_W, 1'b0);
        #1 v1 = bus.data_read;
        repeat (4) ld(32'h4000_0000, MEM_W, 1'b0);
        ld(MB + 32'h4, MEM_W, 1'b0);
        #1 v2 = bus.data_read;
        check("cycle_delta", v2 - v1, 32'd5);

        st(MB, 32'h0000_A5A5, MEM_W, 1'b0);
        for (int i = 0; i < 3; i++) st(MB + 32'hC, 32'hC0 + i, MEM_W, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        req_v = 1'b0;
        bus.data_we = 1'b0;
        c_we = 1'b0; c_rdy = 1'b0;
        mq.delete(); sbq.delete();
        ovf_m = 1'b0; led_m = '0;
        #1;
        check("mid_rst tx_valid", 32'(bus.tx_valid), 32'h0);
        check("mid_rst led", 32'(led), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 600; i++) begin
            cls = $urandom_range(99);
            rop = 3'($urandom_range(7));
            if (cls < 60)      ra = $urandom_range(255);
            else if (cls < 65) ra = 32'hFFF0 + $urandom_range(15);
            else if (cls < 80) ra = MB + $urandom_range(19);
            else if (cls < 90) begin
                ra = MB + 32'hC;
                rop = MEM_W;
            end
            else if (cls < 95) ra = RAMB + $urandom_range(7);
            else               ra = MB + 32'h40 + $urandom_range(7);
            step(ra, $urandom, 1'($urandom_range(1)), rop,
                 ((i / 40) % 2 == 1) ? ($urandom_range(3) != 0)
                                     : ($urandom_range(3) == 0),
                 "rand", 0, '0);
        end

        repeat (12) ld(32'h4000_0000, MEM_W, 1'b1);
        ld(32'h4000_0000, MEM_W, 1'b0);
        @(negedge clk);
        #1 req_v = 1'b0;
        check("final_drain", 32'(sbq.size()), 32'd0);
        check("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
